// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse queue player.
//   state_t       - player FSM states
//   morse_sym_t   - {length, left-aligned pattern} of one letter (1 = dash)
//   morse_lookup  - A..Z table, code 0 = 'A'
package morse_pkg;

  localparam int MORSE_MAX_LEN = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MARK  = 3'd2,
    SPACE = 3'd3,
    GAP   = 3'd4
  } state_t;

  // pat is MSB first: element 0 sits in pat[MORSE_MAX_LEN-1], unused tail bits are 0
  typedef struct packed {
    logic [2:0]               len;
    logic [MORSE_MAX_LEN-1:0] pat;
  } morse_sym_t;

  function automatic morse_sym_t morse_lookup(input logic [4:0] code);
    morse_sym_t sym;
    case (code)
      5'd0:    sym = '{len: 3'd2, pat: 4'b0100}; // A .-
      5'd1:    sym = '{len: 3'd4, pat: 4'b1000}; // B -...
      5'd2:    sym = '{len: 3'd4, pat: 4'b1010}; // C -.-.
      5'd3:    sym = '{len: 3'd3, pat: 4'b1000}; // D -..
      5'd4:    sym = '{len: 3'd1, pat: 4'b0000}; // E .
      5'd5:    sym = '{len: 3'd4, pat: 4'b0010}; // F ..-.
      5'd6:    sym = '{len: 3'd3, pat: 4'b1100}; // G --.
      5'd7:    sym = '{len: 3'd4, pat: 4'b0000}; // H ....
      5'd8:    sym = '{len: 3'd2, pat: 4'b0000}; // I ..
      5'd9:    sym = '{len: 3'd4, pat: 4'b0111}; // J .---
      5'd10:   sym = '{len: 3'd3, pat: 4'b1010}; // K -.-
      5'd11:   sym = '{len: 3'd4, pat: 4'b0100}; // L .-..
      5'd12:   sym = '{len: 3'd2, pat: 4'b1100}; // M --
      5'd13:   sym = '{len: 3'd2, pat: 4'b1000}; // N -.
      5'd14:   sym = '{len: 3'd3, pat: 4'b1110}; // O ---
      5'd15:   sym = '{len: 3'd4, pat: 4'b0110}; // P .--.
      5'd16:   sym = '{len: 3'd4, pat: 4'b1101}; // Q --.-
      5'd17:   sym = '{len: 3'd3, pat: 4'b0100}; // R .-.
      5'd18:   sym = '{len: 3'd3, pat: 4'b0000}; // S ...
      5'd19:   sym = '{len: 3'd1, pat: 4'b1000}; // T -
      5'd20:   sym = '{len: 3'd3, pat: 4'b0010}; // U ..-
      5'd21:   sym = '{len: 3'd4, pat: 4'b0001}; // V ...-
      5'd22:   sym = '{len: 3'd3, pat: 4'b0110}; // W .--
      5'd23:   sym = '{len: 3'd4, pat: 4'b1001}; // X -..-
      5'd24:   sym = '{len: 3'd4, pat: 4'b1011}; // Y -.--
      5'd25:   sym = '{len: 3'd4, pat: 4'b1100}; // Z --..
      default: sym = '{len: 3'd1, pat: 4'b0000}; // unreachable codes play a single dot
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH a power of two.
//   clk, rst_n        - clock, async active-low reset
//   flush             - synchronous empty (wins over push/pop)
//   push, din         - write request and data (accepted when full if pop is accepted too)
//   pop, dout         - read request; dout shows the head combinationally
//   full, empty, count
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_ok_s, push_ok_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers and occupancy; pointers wrap on their natural width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      if (push_ok_s && !pop_ok_s)      count_r <= count_r + CW'(1);
      else if (pop_ok_s && !push_ok_s) count_r <= count_r - CW'(1);
    end
  end

endmodule

// File: rtl/morse_queue_player.sv
// morse_queue_player: letter buttons queue characters that are played as Morse
// tone on a piezo buzzer.
//   clk, rst_n  - clock, async active-low reset
//   btn         - raw push buttons, button i = letter 'A'+i
//   abort       - flush queue and stop playback
//   clr_ovf     - clear sticky overflow
//   buzzer      - square-wave drive, only during MARK
//   busy        - player not IDLE
//   fifo_count  - queued characters
//   overflow    - a press was dropped on a full queue
module morse_queue_player
  import morse_pkg::*;
#(
  parameter int NUM_BTN    = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int UNIT_CYC   = 2500000,
  parameter int TONE_DIV   = 15625
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_BTN-1:0]              btn,
  input  logic                            abort,
  input  logic                            clr_ovf,
  output logic                            buzzer,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int UW = $clog2(3*UNIT_CYC);
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [UW-1:0] DOT_LAST  = UW'(UNIT_CYC-1);
  localparam logic [UW-1:0] DASH_LAST = UW'(3*UNIT_CYC-1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV-1);

  logic [NUM_BTN-1:0] sync1_r, sync2_r, prev_r, rise_s;
  logic [1:0]         prime_r;
  logic               hit_s, push_r, ovf_r;
  logic [4:0]         code_s, code_r, char_r, fifo_dout_s;
  logic               fifo_full_s, fifo_empty_s, pop_s, adv_s;
  state_t             state_r, state_n;
  morse_sym_t         sym_s;
  logic [2:0]         len_r;
  logic [3:0]         pat_r;
  logic [1:0]         idx_r, bit_sel_s;
  logic               dash_s, last_elem_s;
  logic [UW-1:0]      unit_cnt_r, mark_last_s;
  logic [TW-1:0]      tone_cnt_r;
  logic               tone_r;

  // synchroniser and edge reference; prev is held at all-ones until the
  // synchroniser has filled so a button held through reset is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {NUM_BTN{1'b0}};
      sync2_r <= {NUM_BTN{1'b0}};
      prev_r  <= {NUM_BTN{1'b1}};
      prime_r <= 2'd0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      if (prime_r == 2'd2) begin
        prev_r <= sync2_r;
      end else begin
        prev_r  <= {NUM_BTN{1'b1}};
        prime_r <= prime_r + 2'd1;
      end
    end
  end

  assign rise_s = sync2_r & ~prev_r;
  assign hit_s  = |rise_s;

  // lowest-index rising edge wins; the rest are discarded silently
  always_comb begin
    code_s = 5'd0;
    for (int i = NUM_BTN-1; i >= 0; i--) begin
      code_s = rise_s[i] ? 5'(i) : code_s;
    end
  end

  // detected code, written into the FIFO one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_r <= 1'b0;
      code_r <= 5'd0;
    end else begin
      push_r <= hit_s;
      code_r <= code_s;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push_r & ~abort),
    .din   (code_r),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  // sticky overflow; a set in the same cycle beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (push_r && fifo_full_s && !pop_s && !abort) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end
  end

  assign sym_s       = morse_lookup(char_r);
  assign bit_sel_s   = 2'(MORSE_MAX_LEN-1) - idx_r;
  assign dash_s      = pat_r[bit_sel_s];
  assign mark_last_s = dash_s ? DASH_LAST : DOT_LAST;
  assign last_elem_s = (({1'b0, idx_r} + 3'd1) == len_r);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_n;
  end

  // FSM next state, FIFO pop and element advance
  always_comb begin
    state_n = state_r;
    pop_s   = 1'b0;
    adv_s   = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            state_n = LOAD;
          end else begin
            state_n = IDLE;
          end
        end
        LOAD: state_n = MARK;
        MARK: begin
          if (unit_cnt_r == mark_last_s) begin
            state_n = last_elem_s ? GAP : SPACE;
          end else begin
            state_n = MARK;
          end
        end
        SPACE: begin
          if (unit_cnt_r == DOT_LAST) begin
            adv_s   = 1'b1;
            state_n = MARK;
          end else begin
            state_n = SPACE;
          end
        end
        GAP: begin
          if (unit_cnt_r == DASH_LAST) state_n = IDLE;
          else                         state_n = GAP;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // character, symbol, element index and unit timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_r     <= 5'd0;
      len_r      <= 3'd0;
      pat_r      <= 4'd0;
      idx_r      <= 2'd0;
      unit_cnt_r <= {UW{1'b0}};
    end else begin
      if (pop_s) char_r <= fifo_dout_s;
      if (state_r == LOAD) begin
        len_r <= sym_s.len;
        pat_r <= sym_s.pat;
        idx_r <= 2'd0;
      end else if (adv_s) begin
        idx_r <= idx_r + 2'd1;
      end
      // the timer restarts on every state change so each state counts from 0
      if (state_r == IDLE || state_n != state_r) unit_cnt_r <= {UW{1'b0}};
      else                                       unit_cnt_r <= unit_cnt_r + UW'(1);
    end
  end

  // tone generator: starts high on MARK entry, forced low elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_r     <= 1'b0;
      tone_cnt_r <= {TW{1'b0}};
    end else if (state_n == MARK) begin
      if (state_r != MARK) begin
        tone_r     <= 1'b1;
        tone_cnt_r <= {TW{1'b0}};
      end else if (tone_cnt_r == TONE_LAST) begin
        tone_r     <= ~tone_r;
        tone_cnt_r <= {TW{1'b0}};
      end else begin
        tone_cnt_r <= tone_cnt_r + TW'(1);
      end
    end else begin
      tone_r     <= 1'b0;
      tone_cnt_r <= {TW{1'b0}};
    end
  end

  assign buzzer   = tone_r;
  assign busy     = (state_r != IDLE);
  assign overflow = ovf_r;

endmodule
